// File: rtl/ahfp_pkg.sv
// rtl/ahfp_pkg.sv - shared single-precision constants, operand classes and divider states
package ahfp_pkg;

   localparam int          EXP_W   = 8;
   localparam int          MAN_W   = 23;
   localparam int          BIAS    = 127;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} op_class_t;

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_DONE} div_state_t;

endpackage

// File: rtl/ahfp_unpack.sv
// rtl/ahfp_unpack.sv - split a float into fields and classify it; denormals read as zero
module ahfp_unpack
   import ahfp_pkg::*;
#(
   parameter int EXP_W = ahfp_pkg::EXP_W,
   parameter int MAN_W = ahfp_pkg::MAN_W
)(
   input  logic [EXP_W+MAN_W:0] op,
   output logic                 sign,
   output logic [EXP_W-1:0]     exponent,
   output logic [MAN_W:0]       mantissa,
   output op_class_t            cls
);

   assign sign     = op[EXP_W+MAN_W];
   assign exponent = op[EXP_W+MAN_W-1:MAN_W];
   assign mantissa = {1'b1, op[MAN_W-1:0]};

   always_comb begin
      cls = NORMAL;
      if (exponent == '0)
         cls = ZERO;
      else if (&exponent)
         cls = (|op[MAN_W-1:0]) ? NAN : INF;
   end

endmodule

// File: rtl/ahfp_div_multi.sv
// rtl/ahfp_div_multi.sv - multi-cycle single-precision divider, restoring radix-2, truncating
module ahfp_div_multi
   import ahfp_pkg::*;
#(
   parameter int                   EXP_W = ahfp_pkg::EXP_W,
   parameter int                   MAN_W = ahfp_pkg::MAN_W,
   parameter int                   BIAS  = ahfp_pkg::BIAS,
   parameter logic [EXP_W+MAN_W:0] QNAN  = ahfp_pkg::QNAN
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clk_en,
   input  logic                 start,
   input  logic [EXP_W+MAN_W:0] dataa,
   input  logic [EXP_W+MAN_W:0] datab,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 done
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int M  = MAN_W + 1;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] E_ZERO = '0;
   localparam logic signed [EW-1:0] E_ONE  = EW'(1);
   localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
   localparam logic [4:0]           LAST_IT = 5'(M);

   div_state_t             state;
   logic [W-1:0]           a_q, b_q;
   logic                   a_s, b_s, sgn, special;
   logic [EXP_W-1:0]       a_e, b_e;
   logic [M-1:0]           a_m, b_m;
   op_class_t              a_c, b_c;
   logic [M:0]             rem, quo;
   logic [4:0]             cnt;
   logic signed [EW-1:0]   e, e_adj;
   logic [MAN_W-1:0]       frac;
   logic [W-1:0]           special_res, norm_res, inf_res, zero_res;

   ahfp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
      .op(a_q), .sign(a_s), .exponent(a_e), .mantissa(a_m), .cls(a_c)
   );

   ahfp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
      .op(b_q), .sign(b_s), .exponent(b_e), .mantissa(b_m), .cls(b_c)
   );

   assign sgn      = a_s ^ b_s;
   assign inf_res  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   assign zero_res = {sgn, {(W-1){1'b0}}};

   // Invalid cases are tested first so they win over the inf/zero rules below.
   always_comb begin
      special     = 1'b1;
      special_res = QNAN;
      if (a_c == NAN || b_c == NAN || (a_c == ZERO && b_c == ZERO) ||
          (a_c == INF && b_c == INF))
         special_res = QNAN;
      else if (b_c == ZERO || a_c == INF)
         special_res = inf_res;
      else if (a_c == ZERO || b_c == INF)
         special_res = zero_res;
      else
         special = 1'b0;
   end

   // Quotient lies in (0.5, 2); a clear top bit means one extra normalising shift.
   always_comb begin
      e_adj = quo[M] ? e : e - E_ONE;
      frac  = quo[M] ? quo[M-1:1] : quo[M-2:0];
      if (e_adj >= E_MAX)
         norm_res = inf_res;
      else if (e_adj <= E_ZERO)
         norm_res = zero_res;
      else
         norm_res = {sgn, e_adj[EXP_W-1:0], frac};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         done   <= 1'b0;
         result <= '0;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         rem    <= '0;
         quo    <= '0;
         e      <= '0;
      end else if (clk_en) begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_q   <= dataa;
                  b_q   <= datab;
                  state <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               if (special) begin
                  result <= special_res;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  rem   <= {1'b0, a_m};
                  quo   <= '0;
                  cnt   <= '0;
                  e     <= EW'(a_e) - EW'(b_e) + E_BIAS;
                  state <= S_DIVIDE;
               end
            end
            S_DIVIDE: begin
               if (rem >= {1'b0, b_m}) begin
                  quo <= {quo[M-1:0], 1'b1};
                  rem <= (rem - {1'b0, b_m}) << 1;
               end else begin
                  quo <= {quo[M-1:0], 1'b0};
                  rem <= rem << 1;
               end
               cnt <= cnt + 5'd1;
               if (cnt == LAST_IT)
                  state <= S_NORM;
            end
            S_NORM: begin
               result <= norm_res;
               done   <= 1'b1;
               state  <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ahfp_div_multi.sv
// tb/tb_ahfp_div_multi.sv - randomized self-checking bench for ahfp_div_multi
module tb_ahfp_div_multi;

   typedef struct {
      logic [31:0] res;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_en = 1'b1;
   logic        start = 1'b0;
   logic [31:0] dataa = '0;
   logic [31:0] datab = '0;
   logic [31:0] result;
   logic        done;

   int   total = 0;
   int   bad = 0;
   int   ecnt = 0;
   int   tcnt = 0;
   int   done_t = 0;
   bit   last_en = 1'b0;
   bit   last_rst = 1'b1;
   logic        prev_done = 1'b0;
   logic [31:0] prev_result = '0;
   exp_t exp_q[$];

   ahfp_div_multi dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
      .dataa(dataa), .datab(datab), .result(result), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   // Reference: exact integer quotient of the significands, truncated to 24 bits.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         output int lat);
      int ea, eb, e;
      logic sg;
      bit an, ai, az, bn, bi, bz;
      longint unsigned ma, mb, qq, fr;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      sg = a[31] ^ b[31];
      an = (ea == 255) && (a[22:0] != 0);
      ai = (ea == 255) && (a[22:0] == 0);
      az = (ea == 0);
      bn = (eb == 255) && (b[22:0] != 0);
      bi = (eb == 255) && (b[22:0] == 0);
      bz = (eb == 0);
      lat = 2;
      if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC0_0000;
      if (bz || ai) return {sg, 31'h7F80_0000};
      if (az || bi) return {sg, 31'h0};
      lat = 28;
      ma = 64'h80_0000 + 64'(a[22:0]);
      mb = 64'h80_0000 + 64'(b[22:0]);
      qq = (ma << 24) / mb;
      e  = ea - eb + 127;
      if (qq >= 64'h100_0000) fr = qq >> 1;
      else begin
         fr = qq;
         e  = e - 1;
      end
      if (e >= 255) return {sg, 31'h7F80_0000};
      if (e <= 0) return {sg, 31'h0};
      return {sg, e[7:0], fr[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      int k, ex;
      logic [22:0] fr;
      k  = $urandom_range(0, 9);
      ex = (k == 0) ? 0 : (k == 1) ? 255 : (k == 2) ? ($urandom_range(0, 1) ? 254 : 1)
         : 100 + $urandom_range(0, 55);
      fr = ($urandom_range(0, 4) == 0) ? 23'h0 : 23'($urandom);
      return {1'($urandom), ex[7:0], fr};
   endfunction

   always @(posedge clk) begin
      tcnt     <= tcnt + 1;
      if (!reset && clk_en) ecnt <= ecnt + 1;
      last_en  <= clk_en && !reset;
      last_rst <= reset;
   end

   // Single compare process: outputs checked after every edge.
   always @(negedge clk) begin
      exp_t x;
      if (last_rst) begin
         check("reset_done", {31'h0, done}, 32'h0);
         check("reset_result", result, 32'h0);
      end else if (!last_en) begin
         check("hold_done", {31'h0, done}, {31'h0, prev_done});
         check("hold_result", result, prev_result);
      end else if (done) begin
         if (exp_q.size() == 0) check("spurious_done", {31'h0, done}, 32'h0);
         else begin
            x = exp_q.pop_front();
            done_t = tcnt;
            check("result", result, x.res);
            check("latency", 32'(ecnt), 32'(x.due));
         end
      end else if (exp_q.size() != 0 && ecnt >= exp_q[0].due) begin
         check("late_done", {31'h0, done}, 32'h1);
         void'(exp_q.pop_front());
      end
      prev_done   = done;
      prev_result = result;
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      exp_t x;
      int lat;
      x.res = model(a, b, lat);
      x.due = ecnt + lat;
      exp_q.push_back(x);
      dataa  = a;
      datab  = b;
      start  = 1'b1;
      clk_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dataa = $urandom;
      datab = $urandom;
   endtask

   task automatic finish_op(input bit rnd_en);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         clk_en = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         n++;
      end
      clk_en = 1'b1;
      if (exp_q.size() != 0) begin
         check("timeout", 32'(exp_q.size()), 32'h0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit rnd_en);
      issue(a, b);
      finish_op(rnd_en);
   endtask

   initial begin
      int lat, t0;
      check("pin_6_2", model(32'h40C0_0000, 32'h4000_0000, lat), 32'h4040_0000);
      check("pin_6_2_lat", 32'(lat), 32'd28);
      check("pin_1_3", model(32'h3F80_0000, 32'h4040_0000, lat), 32'h3EAA_AAAA);
      check("pin_m1_0", model(32'hBF80_0000, 32'h0000_0000, lat), 32'hFF80_0000);
      check("pin_m1_0_lat", 32'(lat), 32'd2);
      check("pin_0_0", model(32'h0, 32'h0, lat), 32'h7FC0_0000);
      check("pin_ovf", model(32'h7F00_0000, 32'h0080_0000, lat), 32'h7F80_0000);
      check("pin_unf", model(32'h0080_0000, 32'h7F00_0000, lat), 32'h0000_0000);

      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      run_op(32'h40C0_0000, 32'h4000_0000, 1'b0);
      run_op(32'h3F80_0000, 32'h4040_0000, 1'b0);
      run_op(32'hBF80_0000, 32'h0000_0000, 1'b0);
      run_op(32'h0000_0000, 32'h0000_0000, 1'b0);
      run_op(32'h7F00_0000, 32'h0080_0000, 1'b0);
      run_op(32'h0080_0000, 32'h7F00_0000, 1'b0);
      run_op(32'h7F80_0000, 32'h7F80_0000, 1'b0);
      run_op(32'h7F80_0001, 32'h3F80_0000, 1'b0);
      run_op(32'hC000_0000, 32'h7F80_0000, 1'b0);

      // Stall mid-divide, with a stray start while busy.
      t0 = tcnt;
      issue(32'h40C0_0000, 32'h4000_0000);
      repeat (4) @(negedge clk);
      start = 1'b1;
      dataa = 32'h3F80_0000;
      datab = 32'h4040_0000;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      clk_en = 1'b0;
      repeat (5) @(negedge clk);
      clk_en = 1'b1;
      finish_op(1'b0);
      check("stall_delay", 32'(done_t - t0), 32'd33);

      // Reset during iteration 10 aborts silently.
      dataa = 32'h40C0_0000;
      datab = 32'h4000_0000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (35) @(negedge clk);
      check("post_reset_result", result, 32'h0);
      check("post_reset_done", {31'h0, done}, 32'h0);
      run_op(32'h3F80_0000, 32'h4040_0000, 1'b0);

      for (int i = 0; i < 40; i++)
         run_op(rand_fp(), rand_fp(), i[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
